writeback_queue: RTL and testbench



---
 rtl/wb_pkg.sv | 19 +
 rtl/wb_fifo.sv | 67 ++++++
 rtl/writeback_queue.sv | 126 ++++++++++++
 tb/tb_writeback_queue.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types for the writeback queue: register address/data widths, the
// buffered entry record and the drain state encoding.
package wb_pkg;

  localparam int REG_COUNT = 16;
  localparam int DIR_W     = $clog2(REG_COUNT);
  localparam int DATA_W    = 32;

  typedef struct packed {
    logic [DIR_W-1:0]  dir;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    WB_IDLE,
    WB_WRITE
  } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer of writeback entries: two pushes (slot 0 first) and one pop
// per cycle, with all entries exposed oldest-first for hazard matching.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_push0,
  input  wb_entry_t              i_push0Entry,
  input  logic                   i_push1,
  input  wb_entry_t              i_push1Entry,
  input  logic                   i_pop,
  output logic [$clog2(DEPTH):0] o_count,
  output logic [DEPTH-1:0]       o_valid,
  output wb_entry_t              o_entries [DEPTH]
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    r_wrPtr;
  logic [PW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic [DEPTH-1:0] r_valid;
  wb_entry_t        r_mem [DEPTH];

  logic             w_pop;
  logic [PW-1:0]    w_slot1;

  // Overflow is prevented upstream by the ready logic, so pushes are trusted.
  assign w_pop   = i_pop && (r_count != '0);
  assign w_slot1 = i_push0 ? r_wrPtr + PW'(1) : r_wrPtr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
      r_valid <= '0;
    end else begin
      if (w_pop)   r_valid[r_rdPtr] <= 1'b0;
      if (i_push0) r_valid[r_wrPtr] <= 1'b1;
      if (i_push1) r_valid[w_slot1] <= 1'b1;
      r_wrPtr <= r_wrPtr + PW'(i_push0) + PW'(i_push1);
      r_rdPtr <= r_rdPtr + PW'(w_pop);
      r_count <= r_count + CW'(i_push0) + CW'(i_push1) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (i_push0) r_mem[r_wrPtr] <= i_push0Entry;
    if (i_push1) r_mem[w_slot1] <= i_push1Entry;
  end

  // Rotate so index 0 is the head; higher indices are younger entries.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      o_valid[i]   = r_valid[r_rdPtr + PW'(i)];
      o_entries[i] = r_mem[r_rdPtr + PW'(i)];
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/writeback_queue.sv
// Writeback queue in front of the 16x32 register memory with RAW scoreboard.
// Optional forwarding of the youngest pending value: WRITEBACK_QUEUE_FWD_EN.
module writeback_queue #(
  parameter int DEPTH  = 4,
  parameter int DIR_W  = wb_pkg::DIR_W,
  parameter int DATA_W = wb_pkg::DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   alu_valid,
  input  logic [DIR_W-1:0]       alu_dir,
  input  logic [DATA_W-1:0]      alu_data,
  output logic                   alu_ready,
  input  logic                   mem_valid,
  input  logic [DIR_W-1:0]       mem_dir,
  input  logic [DATA_W-1:0]      mem_data,
  output logic                   mem_ready,
  input  logic                   wr_stall,
  output logic [DIR_W-1:0]       wr_dir,
  output logic [DATA_W-1:0]      wr_data,
  output logic                   reg_we_n,
  input  logic [DIR_W-1:0]       chk_dir,
  output logic                   chk_hit,
  output logic                   fwd_valid,
  output logic [DATA_W-1:0]      fwd_data,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);

  wb_pkg::wb_entry_t w_memEntry;
  wb_pkg::wb_entry_t w_aluEntry;
  wb_pkg::wb_entry_t w_entries [DEPTH];
  logic [DEPTH-1:0]  w_valid;
  logic [CW-1:0]     w_count;
  logic              w_memPush;
  logic              w_aluPush;
  logic              w_pop;
  logic              w_hit;

  wb_pkg::wb_state_t r_state;
  logic [DIR_W-1:0]  r_wrDir;
  logic [DATA_W-1:0] r_wrData;
  logic              r_weN;

  // Ready looks only at registered count, so a same-cycle drain is not credited.
  assign mem_ready = {1'b0, w_count} < DEPTH_C;
  assign alu_ready = ({1'b0, w_count} + (CW+1)'(mem_valid)) < DEPTH_C;
  assign w_memPush = mem_valid && mem_ready;
  assign w_aluPush = alu_valid && alu_ready;
  assign w_pop     = (w_count != '0) && !wr_stall;

  assign w_memEntry.dir  = mem_dir;
  assign w_memEntry.data = mem_data;
  assign w_aluEntry.dir  = alu_dir;
  assign w_aluEntry.data = alu_data;

  wb_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .i_push0      (w_memPush),
    .i_push0Entry (w_memEntry),
    .i_push1      (w_aluPush),
    .i_push1Entry (w_aluEntry),
    .i_pop        (w_pop),
    .o_count      (w_count),
    .o_valid      (w_valid),
    .o_entries    (w_entries)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= wb_pkg::WB_IDLE;
      r_wrDir  <= '0;
      r_wrData <= '0;
      r_weN    <= 1'b1;
    end else if (w_pop) begin
      r_state  <= wb_pkg::WB_WRITE;
      r_wrDir  <= w_entries[0].dir;
      r_wrData <= w_entries[0].data;
      r_weN    <= 1'b0;
    end else begin
      r_state  <= wb_pkg::WB_IDLE;
      r_weN    <= 1'b1;
    end
  end

  assign wr_dir   = r_wrDir;
  assign wr_data  = r_wrData;
  assign reg_we_n = r_weN;

  always_comb begin
    w_hit = (r_state == wb_pkg::WB_WRITE) && (r_wrDir == chk_dir);
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_entries[i].dir == chk_dir)) w_hit = 1'b1;
    end
  end

  assign chk_hit = w_hit;

`ifdef WRITEBACK_QUEUE_FWD_EN
  // Walk oldest to youngest so the youngest match overrides everything older.
  always_comb begin
    fwd_data = '0;
    if ((r_state == wb_pkg::WB_WRITE) && (r_wrDir == chk_dir)) fwd_data = r_wrData;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_valid[i] && (w_entries[i].dir == chk_dir)) fwd_data = w_entries[i].data;
    end
  end
  assign fwd_valid = w_hit;
`else
  assign fwd_valid = 1'b0;
  assign fwd_data  = '0;
`endif

  assign count = w_count;
  assign full  = (w_count == FULL_C);
  assign empty = (w_count == '0);

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue: per-cycle vector table plus a reset-mid-burst
// sequence. Forwarding expectations follow WRITEBACK_QUEUE_FWD_EN.
module tb_writeback_queue;

  localparam int DEPTH = 4;
`ifdef WRITEBACK_QUEUE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        alu_valid;
  logic [3:0]  alu_dir;
  logic [31:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_dir;
  logic [31:0] mem_data;
  logic        mem_ready;
  logic        wr_stall;
  logic [3:0]  wr_dir;
  logic [31:0] wr_data;
  logic        reg_we_n;
  logic [3:0]  chk_dir;
  logic        chk_hit;
  logic        fwd_valid;
  logic [31:0] fwd_data;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  writeback_queue #(
    .DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .alu_valid (alu_valid),
    .alu_dir   (alu_dir),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .mem_valid (mem_valid),
    .mem_dir   (mem_dir),
    .mem_data  (mem_data),
    .mem_ready (mem_ready),
    .wr_stall  (wr_stall),
    .wr_dir    (wr_dir),
    .wr_data   (wr_data),
    .reg_we_n  (reg_we_n),
    .chk_dir   (chk_dir),
    .chk_hit   (chk_hit),
    .fwd_valid (fwd_valid),
    .fwd_data  (fwd_data),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        aluV;
    logic [3:0]  aluDir;
    logic [31:0] aluData;
    logic        memV;
    logic [3:0]  memDir;
    logic [31:0] memData;
    logic        stall;
    logic [3:0]  chk;
    logic        expAluRdy;
    logic        expMemRdy;
    logic [2:0]  expCount;
    logic        expWeN;
    logic [3:0]  expWrDir;
    logic [31:0] expWrData;
    logic        expHit;
    logic [31:0] expFwd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   fails  = 0;
  int   writes;

  function automatic void addVec(input int aV, input int aDir, input int aData,
                                 input int mV, input int mDir, input int mData,
                                 input int stall, input int chk,
                                 input int eAluRdy, input int eMemRdy, input int eCount,
                                 input int eWeN, input int eWrDir, input int eWrData,
                                 input int eHit, input int eFwd);
    vec_t v;
    v.aluV      = 1'(aV);
    v.aluDir    = 4'(aDir);
    v.aluData   = 32'(aData);
    v.memV      = 1'(mV);
    v.memDir    = 4'(mDir);
    v.memData   = 32'(mData);
    v.stall     = 1'(stall);
    v.chk       = 4'(chk);
    v.expAluRdy = 1'(eAluRdy);
    v.expMemRdy = 1'(eMemRdy);
    v.expCount  = 3'(eCount);
    v.expWeN    = 1'(eWeN);
    v.expWrDir  = 4'(eWrDir);
    v.expWrData = 32'(eWrData);
    v.expHit    = 1'(eHit);
    v.expFwd    = 32'(eFwd);
    vecs.push_back(v);
  endfunction

  task automatic applyStimulus(input vec_t v);
    alu_valid = v.aluV;
    alu_dir   = v.aluDir;
    alu_data  = v.aluData;
    mem_valid = v.memV;
    mem_dir   = v.memDir;
    mem_data  = v.memData;
    wr_stall  = v.stall;
    chk_dir   = v.chk;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkVector(input int n, input vec_t v);
    logic        expFwdValid;
    logic [31:0] expFwdData;
    expFwdValid = FWD ? v.expHit : 1'b0;
    expFwdData  = FWD ? v.expFwd : 32'h0;
    checkOutput($sformatf("v%0d alu_ready", n), 32'(alu_ready), 32'(v.expAluRdy));
    checkOutput($sformatf("v%0d mem_ready", n), 32'(mem_ready), 32'(v.expMemRdy));
    checkOutput($sformatf("v%0d count", n),     32'(count),     32'(v.expCount));
    checkOutput($sformatf("v%0d full", n),      32'(full),      32'(v.expCount == 3'd4));
    checkOutput($sformatf("v%0d empty", n),     32'(empty),     32'(v.expCount == 3'd0));
    checkOutput($sformatf("v%0d reg_we_n", n),  32'(reg_we_n),  32'(v.expWeN));
    checkOutput($sformatf("v%0d wr_dir", n),    32'(wr_dir),    32'(v.expWrDir));
    checkOutput($sformatf("v%0d wr_data", n),   wr_data,        v.expWrData);
    checkOutput($sformatf("v%0d chk_hit", n),   32'(chk_hit),   32'(v.expHit));
    checkOutput($sformatf("v%0d fwd_valid", n), 32'(fwd_valid), 32'(expFwdValid));
    checkOutput($sformatf("v%0d fwd_data", n),  fwd_data,       expFwdData);
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " count"},     32'(count),     32'd0);
    checkOutput({tag, " empty"},     32'(empty),     32'd1);
    checkOutput({tag, " full"},      32'(full),      32'd0);
    checkOutput({tag, " reg_we_n"},  32'(reg_we_n),  32'd1);
    checkOutput({tag, " wr_dir"},    32'(wr_dir),    32'd0);
    checkOutput({tag, " wr_data"},   wr_data,        32'd0);
    checkOutput({tag, " chk_hit"},   32'(chk_hit),   32'd0);
    checkOutput({tag, " fwd_valid"}, 32'(fwd_valid), 32'd0);
    checkOutput({tag, " fwd_data"},  fwd_data,       32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    alu_valid = 1'b0;
    alu_dir   = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_dir   = '0;
    mem_data  = '0;
    wr_stall  = 1'b0;
    chk_dir   = '0;

    @(posedge clk);
    #1;
    checkResetState("reset");
    @(negedge clk);
    rst = 1'b0;

    //     alu(v,dir,data)   mem(v,dir,data)   stl chk  aRdy mRdy cnt weN wDir wData     hit fwd
    addVec(0, 0, 0,          0, 0, 0,          0,  0,   1, 1, 0,   1, 0, 0,        0, 0);
    addVec(1, 5, 'h1234,     0, 0, 0,          0,  5,   1, 1, 0,   1, 0, 0,        0, 0);
    addVec(0, 0, 0,          0, 0, 0,          0,  5,   1, 1, 1,   1, 0, 0,        1, 'h1234);
    addVec(0, 0, 0,          0, 0, 0,          0,  5,   1, 1, 0,   0, 5, 'h1234,   1, 'h1234);
    addVec(0, 0, 0,          0, 0, 0,          0,  5,   1, 1, 0,   1, 5, 'h1234,   0, 0);
    addVec(1, 3, 'hBBBB,     1, 2, 'hAAAA,     0,  3,   1, 1, 0,   1, 5, 'h1234,   0, 0);
    addVec(0, 0, 0,          0, 0, 0,          0,  3,   1, 1, 2,   1, 5, 'h1234,   1, 'hBBBB);
    addVec(0, 0, 0,          0, 0, 0,          0,  3,   1, 1, 1,   0, 2, 'hAAAA,   1, 'hBBBB);
    addVec(0, 0, 0,          0, 0, 0,          0,  3,   1, 1, 0,   0, 3, 'hBBBB,   1, 'hBBBB);
    addVec(0, 0, 0,          0, 0, 0,          0,  3,   1, 1, 0,   1, 3, 'hBBBB,   0, 0);
    addVec(1, 1, 'h11,       0, 0, 0,          1,  1,   1, 1, 0,   1, 3, 'hBBBB,   0, 0);
    addVec(1, 3, 'h33,       1, 2, 'h22,       1,  1,   1, 1, 1,   1, 3, 'hBBBB,   1, 'h11);
    addVec(1, 5, 'h55,       1, 4, 'h44,       1,  3,   0, 1, 3,   1, 3, 'hBBBB,   1, 'h33);
    addVec(1, 6, 'h66,       1, 6, 'h67,       1,  4,   0, 0, 4,   1, 3, 'hBBBB,   1, 'h44);
    addVec(0, 0, 0,          1, 6, 'h68,       0,  5,   0, 0, 4,   1, 3, 'hBBBB,   0, 0);
    addVec(0, 0, 0,          0, 0, 0,          1,  1,   1, 1, 3,   0, 1, 'h11,     1, 'h11);
    addVec(0, 0, 0,          0, 0, 0,          0,  1,   1, 1, 3,   1, 1, 'h11,     0, 0);
    addVec(0, 0, 0,          0, 0, 0,          1,  2,   1, 1, 2,   0, 2, 'h22,     1, 'h22);
    addVec(0, 0, 0,          0, 0, 0,          0,  2,   1, 1, 2,   1, 2, 'h22,     0, 0);
    addVec(0, 0, 0,          0, 0, 0,          0,  4,   1, 1, 1,   0, 3, 'h33,     1, 'h44);
    addVec(0, 0, 0,          0, 0, 0,          0,  4,   1, 1, 0,   0, 4, 'h44,     1, 'h44);
    addVec(0, 0, 0,          0, 0, 0,          0,  4,   1, 1, 0,   1, 4, 'h44,     0, 0);
    addVec(1, 7, 1,          0, 0, 0,          1,  7,   1, 1, 0,   1, 4, 'h44,     0, 0);
    addVec(1, 7, 2,          0, 0, 0,          1,  7,   1, 1, 1,   1, 4, 'h44,     1, 1);
    addVec(0, 0, 0,          0, 0, 0,          1,  7,   1, 1, 2,   1, 4, 'h44,     1, 2);
    addVec(0, 0, 0,          0, 0, 0,          0,  7,   1, 1, 2,   1, 4, 'h44,     1, 2);
    addVec(0, 0, 0,          0, 0, 0,          0,  7,   1, 1, 1,   0, 7, 1,        1, 2);
    addVec(0, 0, 0,          0, 0, 0,          0,  7,   1, 1, 0,   0, 7, 2,        1, 2);
    addVec(0, 0, 0,          0, 0, 0,          0,  7,   1, 1, 0,   1, 7, 2,        0, 0);
    addVec(1, 8, 'hBB,       1, 8, 'hAA,       1,  8,   1, 1, 0,   1, 7, 2,        0, 0);
    addVec(0, 0, 0,          0, 0, 0,          1,  8,   1, 1, 2,   1, 7, 2,        1, 'hBB);
    addVec(0, 0, 0,          0, 0, 0,          0,  8,   1, 1, 2,   1, 7, 2,        1, 'hBB);
    addVec(0, 0, 0,          0, 0, 0,          0,  8,   1, 1, 1,   0, 8, 'hAA,     1, 'hBB);
    addVec(0, 0, 0,          0, 0, 0,          0,  8,   1, 1, 0,   0, 8, 'hBB,     1, 'hBB);
    addVec(0, 0, 0,          0, 0, 0,          0,  8,   1, 1, 0,   1, 8, 'hBB,     0, 0);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      applyStimulus(vecs[i]);
      @(negedge clk);
      checkVector(i, vecs[i]);
    end

    // Reset mid-burst: three entries queued, one of them already in the output register.
    @(posedge clk);
    #1;
    wr_stall  = 1'b1;
    alu_valid = 1'b1; alu_dir = 4'd9;  alu_data = 32'h91;
    mem_valid = 1'b1; mem_dir = 4'd10; mem_data = 32'hA0;
    chk_dir   = 4'd9;
    @(posedge clk);
    #1;
    mem_valid = 1'b0;
    alu_dir   = 4'd11; alu_data = 32'hB0;
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    wr_stall  = 1'b0;
    @(posedge clk);
    #2;
    checkOutput("burst reg_we_n", 32'(reg_we_n), 32'd0);
    checkOutput("burst wr_dir",   32'(wr_dir),   32'd10);
    checkOutput("burst count",    32'(count),    32'd2);
    checkOutput("burst chk_hit",  32'(chk_hit),  32'd1);
    #1;
    rst = 1'b1;
    #1;
    checkResetState("midreset");
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    writes = 0;
    repeat (6) begin
      @(negedge clk);
      if (reg_we_n !== 1'b1) writes++;
    end
    checkOutput("post-reset writes", 32'(writes), 32'd0);
    checkOutput("post-reset count",  32'(count),  32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
